// File: rtl/if_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// if_prefetch_buffer
//
// Instruction-fetch prefetch buffer. It issues word-aligned fetch requests to
// an in-order instruction memory and queues the returned words together with
// their PCs in a small FIFO that feeds the IF/ID pipeline register. A
// redirect (taken branch/jump) flushes the FIFO and marks every response
// still in flight as stale, so those responses are dropped when they arrive.
//
// Parameters
//   DEPTH            FIFO entries (power of two, 2..16)
//   MAX_OUTSTANDING  maximum in-flight memory requests (1..DEPTH)
//   RESET_PC         first fetch address after reset
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   synchronous active-high reset
//   imem_req_o     out  fetch request valid
//   imem_addr_o    out  fetch address (word aligned)
//   imem_gnt_i     in   request accepted this cycle
//   imem_rvalid_i  in   response data valid (in order)
//   imem_rdata_i   in   instruction word
//   redirect_i     in   flush and refetch from redirect_pc_i
//   redirect_pc_i  in   new fetch PC, bits [1:0] ignored
//   instr_valid_o  out  FIFO head valid
//   instr_ready_i  in   IF/ID accepts the head
//   instr_o        out  head instruction
//   pc_o           out  head PC
//   pc_plus_4_o    out  head PC + 4 (mod 2^32)
// -----------------------------------------------------------------------------
module if_prefetch_buffer #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Two extra bits so that sums such as count+pending never overflow.
  localparam int unsigned CW = $clog2(DEPTH) + 2;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // FIFO storage
  logic [31:0] r_mem_instr [DEPTH];
  logic [31:0] r_mem_pc    [DEPTH];
  ptr_t        r_wr_ptr;
  ptr_t        r_rd_ptr;

  // Bookkeeping state
  cnt_t        r_count;
  cnt_t        r_pending;
  cnt_t        r_discard;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_resp_pc;

  // Decoded per-cycle events
  logic        w_head_valid;
  logic        w_req;
  logic        w_grant;
  logic        w_rv_ok;
  logic        w_drop;
  logic        w_push;
  logic        w_valid;
  logic        w_pop;
  logic [31:0] w_redirect_pc;
  logic        w_unused_pc_lsb;

  // Event decode: request gating, response classification, pop handshake.
  always_comb begin
    w_head_valid    = (r_count != '0);
    w_redirect_pc   = {redirect_pc_i[31:2], 2'b00};
    w_unused_pc_lsb = ^redirect_pc_i[1:0];
    // Room is reserved for every kept in-flight response, so the FIFO can
    // never overflow; stale responses are bounded by MAX_OUTSTANDING only.
    w_req   = ~rst & ~redirect_i
            & ((r_count + r_pending) < cnt_t'(DEPTH))
            & ((r_pending + r_discard) < cnt_t'(MAX_OUTSTANDING));
    w_grant = w_req & imem_gnt_i;
    // A response with nothing in flight is a protocol error and is ignored.
    w_rv_ok = imem_rvalid_i & ((r_pending + r_discard) != '0);
    w_drop  = w_rv_ok & (r_discard != '0);
    w_push  = w_rv_ok & (r_discard == '0);
    w_valid = w_head_valid & ~redirect_i & ~rst;
    w_pop   = w_valid & instr_ready_i;
  end

  // Control state: PCs, counters and FIFO pointers; redirect wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_pending  <= '0;
      r_discard  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= w_redirect_pc;
      r_resp_pc  <= w_redirect_pc;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      // Everything still in flight becomes stale, minus a response landing now.
      r_discard  <= r_pending + r_discard - cnt_t'(w_rv_ok);
      r_pending  <= '0;
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + ptr_t'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ptr_t'(1);
      end
      r_pending <= r_pending + cnt_t'(w_grant) - cnt_t'(w_push);
      r_discard <= r_discard - cnt_t'(w_drop);
      r_count   <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
    end
  end

  // FIFO data write; contents need no reset because count gates the head.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_i && w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata_i;
      r_mem_pc[r_wr_ptr]    <= r_resp_pc;
    end
  end

  // Output drive; the head fields read as zero while the FIFO is empty.
  always_comb begin
    imem_req_o    = w_req;
    imem_addr_o   = r_fetch_pc;
    instr_valid_o = w_valid;
    if (w_head_valid) begin
      instr_o     = r_mem_instr[r_rd_ptr];
      pc_o        = r_mem_pc[r_rd_ptr];
      pc_plus_4_o = r_mem_pc[r_rd_ptr] + 32'd4;
    end else begin
      instr_o     = 32'h0000_0000;
      pc_o        = 32'h0000_0000;
      pc_plus_4_o = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_if_prefetch_buffer
//
// Bench for if_prefetch_buffer. A behavioural in-order memory answers each
// granted request after a programmable latency (and can hold responses back).
// The stimulus process pushes the PCs it expects to see into a queue; an
// independent monitor pops that queue on every accepted FIFO head and
// compares PC, instruction and PC+4.
// -----------------------------------------------------------------------------
module tb_if_prefetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_4_o;

  if_prefetch_buffer #(
    .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .pc_plus_4_o(pc_plus_4_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;

  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t mq [$];
  int   cyc     = 0;
  bit   hold    = 1'b0;
  bit   gnt_en  = 1'b1;
  int   lat     = 1;

  // Memory content: distinct for every word address used here.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Restart the expected PC stream (a flush discards anything not yet seen).
  task automatic seq_start(input logic [31:0] pc);
    logic [31:0] p;
    exp_q.delete();
    p = pc;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(p);
      p = p + 32'd4;
    end
  endtask

  // Memory model: grant per gnt_en, answer in order after 'lat' cycles.
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      imem_gnt_i = gnt_en;
      if (!hold && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
      end
      #1;
      if (imem_req_o && imem_gnt_i) mq.push_back('{addr: imem_addr_o, due: cyc + lat});
      cyc++;
    end
  end

  // Monitor: every accepted head must match the next expected PC.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (instr_valid_o && instr_ready_i) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got pc %h expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          check("pc_o", pc_o, e);
          check("instr_o", instr_o, mem_word(e));
          check("pc_plus_4_o", pc_plus_4_o, e + 32'd4);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b1;
    seq_start(32'h0000_0000);

    // Reset values
    repeat (3) @(negedge clk);
    #3;
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_pc4", pc_plus_4_o, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0000_0000);

    // Streaming: one instruction per cycle after a 2-cycle startup
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #3;
      check("stream_valid", {31'd0, instr_valid_o}, 32'd1);
    end

    // Backpressure: FIFO fills, requests stop, nothing lost
    @(negedge clk); instr_ready_i = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    check("bp_req", {31'd0, imem_req_o}, 32'd0);
    check("bp_valid", {31'd0, instr_valid_o}, 32'd1);
    @(negedge clk); instr_ready_i = 1'b1;
    repeat (8) @(negedge clk);

    // Redirect with two responses in flight
    @(negedge clk); hold = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("max_outstanding_req", {31'd0, imem_req_o}, 32'd0);
    @(negedge clk); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0100; seq_start(32'h0000_0100);
    #3;
    check("redir_valid", {31'd0, instr_valid_o}, 32'd0);
    check("redir_req", {31'd0, imem_req_o}, 32'd0);
    @(negedge clk); redirect_i = 1'b0; hold = 1'b0;
    #3;
    check("redir_addr", imem_addr_o, 32'h0000_0100);
    repeat (12) @(negedge clk);

    // Redirect coinciding with a response and a pop
    #3;
    check("pre_redir_stream", {31'd0, instr_valid_o}, 32'd1);
    @(negedge clk); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200; seq_start(32'h0000_0200);
    #3;
    check("redir_pop_valid", {31'd0, instr_valid_o}, 32'd0);
    @(negedge clk); redirect_i = 1'b0;
    #3;
    check("redir2_addr", imem_addr_o, 32'h0000_0200);
    repeat (8) @(negedge clk);

    // Misaligned redirect target and 32-bit wrap
    @(negedge clk); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE; seq_start(32'hFFFF_FFFC);
    @(negedge clk); redirect_i = 1'b0;
    #3;
    check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    check("wrap_req", {31'd0, imem_req_o}, 32'd1);
    @(negedge clk); #3;
    check("wrap_addr1", imem_addr_o, 32'h0000_0000);
    repeat (8) @(negedge clk);

    // Reset mid-stream with two responses outstanding
    @(negedge clk); hold = 1'b1;
    repeat (3) @(negedge clk);
    @(negedge clk); rst = 1'b1; gnt_en = 1'b0; seq_start(32'h0000_0000);
    repeat (2) @(negedge clk);
    @(negedge clk); rst = 1'b0; hold = 1'b0;
    #3;
    check("post_rst_addr", imem_addr_o, 32'h0000_0000);
    check("post_rst_req", {31'd0, imem_req_o}, 32'd1);
    check("post_rst_valid0", {31'd0, instr_valid_o}, 32'd0);
    @(negedge clk); #3;
    check("late_rvalid_ignored1", {31'd0, instr_valid_o}, 32'd0);
    @(negedge clk); #3;
    check("late_rvalid_ignored2", {31'd0, instr_valid_o}, 32'd0);
    @(negedge clk); gnt_en = 1'b1;
    repeat (10) @(negedge clk);

    #4;
    check("outputs_seen", {31'd0, (n_pops >= 20)}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
